line_fill_ctrl: RTL
===================

Name: line_fill_ctrl

Overview:
Miss-refill engine directly upstream of the direct-mapped instruction/data cache (1024 lines × 4 words, 3-bit tag, 10-bit index, 2-bit word offset). On a fill request it fetches the four 32-bit words of a line from word-wide main memory over a req/ack handshake. It assembles the 128-bit line in the cache's packing (word 0 at [127:96], word 3 at [31:0]) and presents line, tag and index with a one-cycle done pulse for the cache write.

Parameters:
TAG_W, 3, tag width
INDEX_W, 10, line index width
WORD_W, 32, word width; line width = 4*WORD_W
ACK_TIMEOUT, 64, max cycles waiting for mem_ack per word before abort (≥2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fill_req  in  1  start refill; sampled only in IDLE
fill_tag  in  TAG_W  tag of missing line
fill_index  in  INDEX_W  index of missing line
fill_offset  in  2  requested word offset (used only with CRITICAL_WORD_FIRST_EN)
fill_busy  out  1  high in every state except IDLE
fill_done  out  1  one-cycle pulse; fill_line/fill_tag_q/fill_index_q valid this cycle
fill_err  out  1  one-cycle pulse on timeout abort
fill_line  out  4*WORD_W  assembled line
fill_tag_q  out  TAG_W  captured tag
fill_index_q  out  INDEX_W  captured index
mem_req  out  1  word read request
mem_addr  out  TAG_W+INDEX_W+2  word address {tag,index,word}
mem_ack  in  1  read data valid, one-cycle
mem_rdata  in  WORD_W  read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; word counter, timeout counter, line buffer cleared. Reset mid-fill aborts with no done/err pulse; mem_req drops immediately.
- States: IDLE, FETCH, DONE, ERR.
- IDLE: fill_req=1 → capture tag/index (and offset), word ptr=0, go FETCH next cycle. fill_req=0 → stay.
- FETCH: mem_req=1, mem_addr={tag_q,index_q,ptr}. mem_addr is stable while awaiting ack. On mem_ack: write mem_rdata into slot ptr, ptr+1 (2-bit), clear timeout counter. mem_req stays high; mem_addr shows the new ptr the following cycle. Ack on 4th word → DONE. Minimum fill latency with same-cycle acks: 4 FETCH cycles + 1 DONE.
- mem_ack while mem_req=0 (IDLE/DONE/ERR): ignored, no buffer change.
- Timeout: counter increments each FETCH cycle without ack. Reaching ACK_TIMEOUT-1 without ack → ERR; mem_req=0 in ERR.
- DONE: fill_done=1 for exactly one cycle, mem_req=0 → IDLE. fill_line, fill_tag_q and fill_index_q hold their values until the next fill captures.
- ERR: fill_err=1 for one cycle → IDLE; fill_line is not updated from the partial buffer (holds previous completed line).
- fill_req while busy (including DONE/ERR cycles): ignored, not queued. The requester must re-assert after done/err.
- Width rule: mem_addr = tag(3)+index(10)+word(2) = 15 bits by default.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: the first fetch uses ptr=fill_offset, and subsequent fetches wrap modulo 4 (e.g., offset 2 → 2,3,0,1). Each word is written to its true slot. Adds output crit_valid (1 bit), a one-cycle pulse on the first ack, and crit_word (WORD_W), which holds that word.
- Undefined: always in order 0,1,2,3; fill_offset unused; crit_valid/crit_word ports absent.

Decomposition:
- Package cache_pkg: TAG_W, INDEX_W, WORD_W, WORDS_PER_LINE=4, LINE_W, ADDR_W; fill state enum (IDLE, FETCH, DONE, ERR); function for word slot → line bit position ([127-32*k -: 32]).
- Natural sub-module: line_fill_buf, a 4-word line buffer with write-enable/slot input, clear, and a packed 128-bit output. FSM and counters stay in line_fill_ctrl.

Test Plan:
- Basic fill: tag=3'b101, index=10'h2A5, mem_ack same cycle as req, rdata=A0,A1,A2,A3 → mem_addr sequence {101,2A5,0..3}. fill_done pulses 5 cycles after fill_req. fill_line=={A0,A1,A2,A3}, fill_tag_q=101, fill_index_q=2A5.
- Variable latency: acks after 0,3,1,7 wait cycles → mem_addr stable during each wait; done after last ack+1; fill_line correct.
- Timeout: ACK_TIMEOUT=8, no ack for word 2 → fill_err pulses once, mem_req low, fill_line equals the previous line, fill_done never asserts.
- Request while busy plus spurious ack: fill_req re-pulsed mid-fill and mem_ack pulsed in IDLE → only one fill_done, the buffer is unaffected by the spurious ack, and the second request is not serviced.
- Reset mid-fill: rst_n low after 2 acks → outputs 0 asynchronously. A new fill after reset fetches from word 0 and completes correctly.
- CRITICAL_WORD_FIRST_EN: fill_offset=2 → addr words 2,3,0,1; crit_valid pulses with crit_word=A2 on the first ack; fill_line=={A0,A1,A2,A3}.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared geometry, fill FSM state type and line packing helper
//             for the direct-mapped cache refill path.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int TAG_W          = 3;
    localparam int INDEX_W        = 10;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int ADDR_W         = TAG_W + INDEX_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } fill_state_t;

    // Word 0 sits in the most significant slot of the line.
    function automatic int slot_msb(input int slot);
        return LINE_W - 1 - WORD_W * slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_ctrl_if
//  Purpose  : Word-wide main memory read port (req/ack handshake).
//             master = refill engine, slave = memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface line_fill_ctrl_if;
    import cache_pkg::*;

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [WORD_W-1:0]     mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/line_fill_ctrl_buf.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_buf
//  Purpose  : Four-word line assembly buffer. Exposes both the registered
//             line and the line as it will look after the pending write, so
//             the controller can publish a complete line on the last ack.
//  Revision : 1.0 - initial release
// ============================================================================
module line_fill_buf
    import cache_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr,
    input  wire logic              we,
    input  wire logic [1:0]        slot,
    input  wire logic [WORD_W-1:0] wdata,
    output logic      [LINE_W-1:0] line_q,
    output logic      [LINE_W-1:0] line_d
);

    // Next buffer contents: clear wins over a write.
    always_comb begin
        line_d = line_q;
        if (clr) begin
            line_d = '0;
        end else if (we) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                if (int'(slot) == k) begin
                    line_d[slot_msb(k) -: WORD_W] = wdata;
                end
            end
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_ctrl
//  Purpose  : Cache miss refill engine. Fetches the four words of a line over
//             a req/ack memory port, assembles them and pulses fill_done with
//             line/tag/index for the cache write, or fill_err on ack timeout.
//  Options  : CRITICAL_WORD_FIRST_EN - start at fill_offset, wrap modulo 4,
//             and report the first returned word on crit_valid/crit_word.
//  Revision : 1.0 - initial release
// ============================================================================
module line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               fill_req,
    input  wire logic [TAG_W-1:0]   fill_tag,
    input  wire logic [INDEX_W-1:0] fill_index,
    input  wire logic [1:0]         fill_offset,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic                    fill_err,
    output logic [LINE_W-1:0]       fill_line,
    output logic [TAG_W-1:0]        fill_tag_q,
    output logic [INDEX_W-1:0]      fill_index_q,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic                    crit_valid,
    output logic [WORD_W-1:0]       crit_word,
`endif
    line_fill_ctrl_if.master        mem
);

    localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    fill_state_t         state;
    fill_state_t         state_nx;
    logic [1:0]          ptr;
    logic [1:0]          nword;
    logic [TO_W-1:0]     to_cnt;
    logic [1:0]          start_ptr;
    logic                start;
    logic                take;
    logic                last;
    logic                tmo;
    logic [LINE_W-1:0]   buf_q;
    logic [LINE_W-1:0]   buf_d;

    assign start = (state == IDLE)  && fill_req;
    assign take  = (state == FETCH) && mem.mem_ack;
    assign last  = take && (nword == 2'd3);
    assign tmo   = (state == FETCH) && !mem.mem_ack && (to_cnt == TO_LAST);

`ifdef CRITICAL_WORD_FIRST_EN
    logic first;
    assign start_ptr = fill_offset;
`else
    logic unused_offset;
    assign start_ptr     = 2'd0;
    assign unused_offset = ^fill_offset;
`endif

    line_fill_buf u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .we     (take),
        .slot   (ptr),
        .wdata  (mem.mem_rdata),
        .line_q (buf_q),
        .line_d (buf_d)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: DONE and ERR are single-cycle report states.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   begin
                         if (last)     state_nx = DONE;
                         else if (tmo) state_nx = ERR;
                     end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs; mem_req falls with the async reset of state.
    always_comb begin
        fill_busy    = (state != IDLE);
        fill_done    = (state == DONE);
        fill_err     = (state == ERR);
        mem.mem_req  = (state == FETCH);
        mem.mem_addr = {fill_tag_q, fill_index_q, ptr};
    end

    // Request capture and word/ack-timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_tag_q   <= '0;
            fill_index_q <= '0;
            ptr          <= '0;
            nword        <= '0;
            to_cnt       <= '0;
        end else if (start) begin
            fill_tag_q   <= fill_tag;
            fill_index_q <= fill_index;
            ptr          <= start_ptr;
            nword        <= '0;
            to_cnt       <= '0;
        end else if (take) begin
            ptr          <= ptr + 2'd1;
            nword        <= nword + 2'd1;
            to_cnt       <= '0;
        end else if (state == FETCH) begin
            to_cnt       <= to_cnt + 1'b1;
        end
    end

    // Publish the completed line (including the word arriving now) on the last ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line <= '0;
        end else if (last) begin
            fill_line <= buf_d;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    // Critical-word report: one pulse after the first ack of each fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first      <= 1'b0;
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            crit_valid <= take && first;
            if (take && first) begin
                crit_word <= mem.mem_rdata;
            end
            if (start) begin
                first <= 1'b1;
            end else if (take) begin
                first <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire
